fp_mult_pipe_param: RTL and testbench

FP_MULT_PIPE_PARAM -- requirements
Module: fp_mult_pipe_param

---
 rtl/fp_mult_pipe_param.sv | 195 +++++++++++++++++++
 tb/tb_fp_mult_pipe_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_pipe_param.sv
// rtl/fp_mult_pipe_param.sv - three-stage parameterised floating-point multiplier
//
// Purpose: multiplies two IEEE-style operands. The pipeline has three stages:
//   S1 unpacks and classifies the operands, and forms the sign and the exponent sum.
//   S2 forms the significand product.
//   S3 normalises, rounds and packs the result, and sets the status flags.
// Subnormal operands are flushed to zero. Any operand with an all-ones exponent
// produces the exception encoding. A sideband tag travels with each operation.
//
// Build option: define FP_MULT_RNE_EN to make S3 round to nearest, ties to even.
// Without it, S3 truncates the discarded product bits.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   in_valid/in_ready      input handshake for a_operand, b_operand, in_tag
//   out_valid/out_ready    output handshake for result, out_tag and the flags
//   exception              an operand was Inf or NaN
//   overflow               the result saturated to signed infinity
//   underflow              the result flushed to signed zero
module fp_mult_pipe_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a_operand,
  input  logic [EXP_W+MAN_W:0] b_operand,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 exception,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

  // Handshake. A stage advances whenever the stage below it can take its
  // contents, so bubbles collapse even while the output is stalled.
  logic stall, en1, en2, en3;
  logic s1_v_q, s2_v_q, out_valid_q;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall & ~rst;
  assign en3      = ~stall;
  assign en2      = ~s2_v_q | en3;
  assign en1      = ~s1_v_q | en2;

  // S1: unpack, classify, sign, exponent sum
  logic [EXP_W-1:0] ea, eb;
  logic             s1_sign_d, s1_exc_d, s1_zero_d;
  logic signed [XW-1:0] s1_exp_d;
  logic [SW-1:0]    s1_ma_d, s1_mb_d;

  assign ea        = a_operand[EXP_W+MAN_W-1 -: EXP_W];
  assign eb        = b_operand[EXP_W+MAN_W-1 -: EXP_W];
  assign s1_sign_d = a_operand[EXP_W+MAN_W] ^ b_operand[EXP_W+MAN_W];
  assign s1_exc_d  = (&ea) | (&eb);
  assign s1_zero_d = (~|ea) | (~|eb);
  assign s1_exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
  assign s1_ma_d   = {1'b1, a_operand[MAN_W-1:0]};
  assign s1_mb_d   = {1'b1, b_operand[MAN_W-1:0]};

  logic                 s1_sign_q, s1_exc_q, s1_zero_q;
  logic signed [XW-1:0] s1_exp_q;
  logic [SW-1:0]        s1_ma_q, s1_mb_q;
  logic [TAG_W-1:0]     s1_tag_q;

  // S2: significand product
  logic [PW-1:0] s2_prod_d;
  assign s2_prod_d = {{SW{1'b0}}, s1_ma_q} * {{SW{1'b0}}, s1_mb_q};

  logic                 s2_sign_q, s2_exc_q, s2_zero_q;
  logic signed [XW-1:0] s2_exp_q;
  logic [PW-1:0]        s2_prod_q;
  logic [TAG_W-1:0]     s2_tag_q;

  // S3: normalise, round, pack, flags
  logic                 top;
  logic [PW-1:0]        norm;
  logic [MAN_W-1:0]     mant_t, mant_r;
  logic signed [XW-1:0] exp_n, exp_r;
  logic [EXP_W+MAN_W:0] res_d;
  logic                 exc_d, ovf_d, unf_d;
  logic                 unused_norm;
`ifdef FP_MULT_RNE_EN
  logic                 guard, sticky, rnd;
  logic [MAN_W:0]       mant_sum;
`endif

  always_comb begin
    // A product >= 2.0 has its leading one in the top bit. Otherwise shift
    // left so that the hidden bit always sits at PW-1.
    top    = s2_prod_q[PW-1];
    norm   = top ? s2_prod_q : (s2_prod_q << 1);
    mant_t = norm[PW-2 -: MAN_W];
    exp_n  = s2_exp_q + XW'(top);
`ifdef FP_MULT_RNE_EN
    guard       = norm[MAN_W];
    sticky      = |norm[MAN_W-1:0];
    rnd         = guard & (sticky | mant_t[0]);
    mant_sum    = {1'b0, mant_t} + {{MAN_W{1'b0}}, rnd};
    // A carry out means 1.11..1 rounded up to 10.00..0. The mantissa field
    // wraps to zero and the exponent takes the carry.
    mant_r      = mant_sum[MAN_W-1:0];
    exp_r       = exp_n + XW'(mant_sum[MAN_W]);
    unused_norm = norm[PW-1];
`else
    mant_r      = mant_t;
    exp_r       = exp_n;
    unused_norm = ^{norm[PW-1], norm[MAN_W:0]};
`endif
    exc_d = 1'b0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    res_d = {s2_sign_q, exp_r[EXP_W-1:0], mant_r};
    if (s2_exc_q) begin
      exc_d = 1'b1;
      res_d = {s2_sign_q, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (s2_zero_q) begin
      res_d = {s2_sign_q, {(EXP_W+MAN_W){1'b0}}};
    end else if (exp_r >= EMAX) begin
      ovf_d = 1'b1;
      res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (exp_r[XW-1] || exp_r == '0) begin
      unf_d = 1'b1;
      res_d = {s2_sign_q, {(EXP_W+MAN_W){1'b0}}};
    end
  end

  logic [EXP_W+MAN_W:0] result_q;
  logic [TAG_W-1:0]     out_tag_q;
  logic                 exc_q, ovf_q, unf_q;

  // Control and output registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      s2_v_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_tag_q   <= '0;
      exc_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      if (en1) s1_v_q <= in_valid & in_ready;
      if (en2) s2_v_q <= s1_v_q;
      if (en3) out_valid_q <= s2_v_q;
      if (en3 && s2_v_q) begin
        result_q  <= res_d;
        out_tag_q <= s2_tag_q;
        exc_q     <= exc_d;
        ovf_q     <= ovf_d;
        unf_q     <= unf_d;
      end
    end
  end

  // Datapath registers. They are only loaded alongside a valid bit, so no reset is needed.
  always_ff @(posedge clk) begin
    if (en1 && in_valid && in_ready) begin
      s1_sign_q <= s1_sign_d;
      s1_exc_q  <= s1_exc_d;
      s1_zero_q <= s1_zero_d;
      s1_exp_q  <= s1_exp_d;
      s1_ma_q   <= s1_ma_d;
      s1_mb_q   <= s1_mb_d;
      s1_tag_q  <= in_tag;
    end
    if (en2 && s1_v_q) begin
      s2_sign_q <= s1_sign_q;
      s2_exc_q  <= s1_exc_q;
      s2_zero_q <= s1_zero_q;
      s2_exp_q  <= s1_exp_q;
      s2_prod_q <= s2_prod_d;
      s2_tag_q  <= s1_tag_q;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign out_tag   = out_tag_q;
  assign exception = exc_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
endmodule

// File: tb/tb_fp_mult_pipe_param.sv
// tb/tb_fp_mult_pipe_param.sv - scoreboard bench for fp_mult_pipe_param
module tb_fp_mult_pipe_param;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_operand = '0;
  logic [31:0] b_operand = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  out_tag;
  logic        exception, overflow, underflow;

  int total = 0;
  int bad   = 0;
  int stall_seen = 0;

  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  t;
    logic [2:0]  f;
  } exp_t;
  exp_t q[$];

  fp_mult_pipe_param dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_operand(a_operand), .b_operand(b_operand), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag),
    .exception(exception), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Called at a falling edge. Returns at the falling edge after the accept.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                      input logic [31:0] r, input logic [2:0] f);
    int n = 0;
    a_operand = a;
    b_operand = b;
    in_tag    = t;
    in_valid  = 1'b1;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout act=%h exp=%h", in_ready, 1'b1);
    end else begin
      q.push_back('{r: r, t: t, f: f});
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Called #1 after the falling edge that follows the accept edge.
  task automatic check_latency(input string nm);
    chk({nm, "_lat1"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk); #1;
    chk({nm, "_lat2"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk); #1;
    chk({nm, "_lat3"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain"}, q.size(), 32'd0);
  endtask

  // Monitor: the head of the queue must be presented for as long as it sits
  // at the output. It is popped only when the consumer takes it.
  always begin : monitor
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output act=%h exp=none", result);
      end else begin
        e = q[0];
        chk("result", result, e.r);
        chk("out_tag", {28'd0, out_tag}, {28'd0, e.t});
        chk("flags", {29'd0, exception, overflow, underflow}, {29'd0, e.f});
        if (!out_ready) begin
          stall_seen++;
          chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end else begin
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_tag", {28'd0, out_tag}, 32'd0);
    chk("rst_flags", {29'd0, exception, overflow, underflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("first_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    send(32'h45800000, 32'h3ABFFFE0, 4'd1, 32'h40BFFFE0, 3'b000);
    #1;
    check_latency("basic");
    @(negedge clk);

    send(32'hC5800000, 32'h3ABFFFE0, 4'd2, 32'hC0BFFFE0, 3'b000);
    send(32'h00000000, 32'h3ABFFFE0, 4'd3, 32'h00000000, 3'b000);
    send(32'h7F000000, 32'h7F000000, 4'd4, 32'h7F800000, 3'b010);
    send(32'h00800000, 32'h00800000, 4'd5, 32'h00000000, 3'b001);
    send(32'h7F800000, 32'h3F800000, 4'd6, 32'h7FC00000, 3'b100);
    send(32'h7F800000, 32'h00000000, 4'd7, 32'h7FC00000, 3'b100);
    send(32'h80000000, 32'h3F800000, 4'd8, 32'h80000000, 3'b000);
    send(32'h40000000, 32'h40000000, 4'd9, 32'h40800000, 3'b000);
    send(32'h40400000, 32'h40400000, 4'd10, 32'h41100000, 3'b000);
    send(32'hBF800000, 32'h3F800000, 4'd11, 32'hBF800000, 3'b000);
`ifdef FP_MULT_RNE_EN
    send(32'h3F800001, 32'h3FC00000, 4'd12, 32'h3FC00002, 3'b000);
    send(32'h3FFFFFFE, 32'h3F800001, 4'd13, 32'h40000000, 3'b000);
`else
    send(32'h3F800001, 32'h3FC00000, 4'd12, 32'h3FC00001, 3'b000);
    send(32'h3FFFFFFE, 32'h3F800001, 4'd13, 32'h3FFFFFFF, 3'b000);
`endif
    drain("directed");

    // Backpressure: five back-to-back ops while the consumer holds off for six cycles.
    out_ready = 1'b0;
    fork
      begin
        repeat (6) @(negedge clk);
        out_ready = 1'b1;
      end
      begin
        send(32'h3F800000, 32'h40000000, 4'd1, 32'h40000000, 3'b000);
        send(32'h3F800000, 32'h40400000, 4'd2, 32'h40400000, 3'b000);
        send(32'h3F800000, 32'h40800000, 4'd3, 32'h40800000, 3'b000);
        send(32'h3F800000, 32'h40A00000, 4'd4, 32'h40A00000, 3'b000);
        send(32'h3F800000, 32'h40C00000, 4'd5, 32'h40C00000, 3'b000);
      end
    join
    drain("backpressure");
    total++;
    if (stall_seen == 0) begin
      bad++;
      $display("FAIL stall_observed act=%0d exp=nonzero", stall_seen);
    end

    // Reset with two ops in flight. They must never appear at the output.
    send(32'h40000000, 32'h40000000, 4'd9, 32'h40800000, 3'b000);
    send(32'h40400000, 32'h40400000, 4'd10, 32'h41100000, 3'b000);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (6) @(negedge clk);
    send(32'h40400000, 32'h40400000, 4'd11, 32'h41100000, 3'b000);
    #1;
    check_latency("postrst");
    @(negedge clk);
    drain("final");
    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
